// File: rtl/apb_mem_completer.sv
// APB4 completer backed by a small word-addressed register memory.
// Inserts WAIT_CYCLES PREADY-low ACCESS cycles, answers bad addresses with
// PSLVERR, and latches requester protocol violations in a sticky proto_err.
module apb_mem_completer #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic                    proto_err,
  input  logic                    proto_err_clr
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(DEPTH * 4);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]           strb_q, strb_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic                    proto_q, proto_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    addr_err;
  logic [IDX_W-1:0]        idx;
  logic                    finish;
  logic                    proto_set;
  logic                    mem_we;

  // Decode always works on the latched address, never on the live bus.
  assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q >= LIMIT);
  assign idx      = addr_q[IDX_W+1:2];
  // Memory is committed on the edge that ends the one-cycle completion.
  assign mem_we   = (state_q == ACCESS) && pready_q && write_q && !addr_err;

  // Next-state, completion and violation decode.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    finish    = 1'b0;
    proto_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          addr_d  = PADDR;
          write_d = PWRITE;
          wdata_d = PWDATA;
          strb_d  = PSTRB;
          state_d = SETUP;
        end else if (PSEL && PENABLE) begin
          proto_set = 1'b1;
        end
      end
      SETUP: begin
        if (PSEL && PENABLE) begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_CYCLES);
          finish  = (WAIT_CYCLES == 0);
        end else begin
          proto_set = 1'b1;
          state_d   = IDLE;
        end
      end
      ACCESS: begin
        if (pready_q) begin
          state_d = IDLE;
        end else if (!PSEL || !PENABLE) begin
          // Abort before completion: nothing written, PREADY never rises.
          proto_set = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d  = cnt_q - 4'd1;
          finish = (cnt_q == 4'd1);
        end
      end
      default: state_d = IDLE;
    endcase

    pready_d  = finish;
    pslverr_d = finish && addr_err;
    prdata_d  = (finish && !write_q && !addr_err) ? mem_q[idx] : '0;
    // A violation in the same cycle as a clear keeps the flag set.
    proto_d   = proto_set ? 1'b1 : (proto_err_clr ? 1'b0 : proto_q);
  end

  // FSM, latched transfer and registered outputs.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      proto_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      proto_q   <= proto_d;
    end
  end

  // Register memory with per-byte write strobes.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      // NOTE: the memory is a register file with a defined zero state, so it is reset here.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (strb_q[b]) mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign PREADY    = pready_q;
  assign PSLVERR   = pslverr_q;
  assign PRDATA    = prdata_q;
  assign proto_err = proto_q;

endmodule

// File: tb/tb_apb_mem_completer.sv
// Bench for apb_mem_completer: two instances (WAIT_CYCLES 0 and 2) share the
// APB bus with separate PSEL lines. The driver queues expected responses; a
// monitor pops and compares whenever an instance raises PREADY.
module tb_apb_mem_completer;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    logic        chk_data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  psel;
  logic        pen, pwrite, clr;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic        rdy0, rdy1, err0, err1, perr0, perr1;
  logic [31:0] rd0, rd1;

  exp_t q0[$];
  exp_t q1[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  apb_mem_completer #(.WAIT_CYCLES(0)) u_w0 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(pen), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(rd0), .PREADY(rdy0),
    .PSLVERR(err0), .proto_err(perr0), .proto_err_clr(clr)
  );

  apb_mem_completer #(.WAIT_CYCLES(2)) u_w2 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(pen), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(rd1), .PREADY(rdy1),
    .PSLVERR(err1), .proto_err(perr1), .proto_err_clr(clr)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor one instance on one sample point.
  task automatic mon(input int t, input logic rdy, input logic slverr, input logic [31:0] rd);
    exp_t e;
    check($sformatf("u%0d_slverr_only_with_pready", t), {31'b0, slverr & ~rdy}, 32'd0);
    if (rdy) begin
      if ((t == 0 && q0.size() == 0) || (t == 1 && q1.size() == 0)) begin
        n_chk++;
        n_fail++;
        $display("FAIL u%0d_unexpected_pready: got PREADY=1 expected no response", t);
      end else begin
        e = (t == 0) ? q0.pop_front() : q1.pop_front();
        check({e.name, "_pslverr"}, {31'b0, slverr}, {31'b0, e.err});
        if (e.chk_data) check({e.name, "_prdata"}, rd, e.rdata);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon(0, rdy0, err0, rd0);
      mon(1, rdy1, err1, rd1);
    end
  end

  // One APB transfer to instance t; starts at posedge+1 and leaves the bus
  // at the following posedge+1 so a further call issues back-to-back.
  // abort_at>0 drops PSEL in that PREADY-low access-phase cycle instead.
  task automatic xfer(input int t, input string nm, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s, input logic [31:0] exp_rd,
                      input logic exp_err, input int abort_at);
    exp_t e;
    int   n_low;
    bit   done, aborted;
    if (abort_at == 0) begin
      e.name     = nm;
      e.rdata    = exp_rd;
      e.err      = exp_err;
      e.chk_data = !wr || exp_err;
      if (t == 0) q0.push_back(e); else q1.push_back(e);
    end
    psel   = (t == 0) ? 2'b01 : 2'b10;
    pen    = 1'b0;
    pwrite = wr;
    paddr  = a;
    pwdata = d;
    pstrb  = s;
    @(posedge clk); #1;
    pen     = 1'b1;
    n_low   = 0;
    done    = 1'b0;
    aborted = 1'b0;
    for (int c = 0; c < 40 && !done && !aborted; c++) begin
      @(negedge clk);
      if ((t == 0) ? rdy0 : rdy1) begin
        done = 1'b1;
      end else begin
        n_low++;
        if (n_low == abort_at) begin
          psel    = 2'b00;
          aborted = 1'b1;
        end
      end
    end
    if (abort_at == 0) begin
      if (!done) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s_timeout: got no PREADY in 40 cycles expected PREADY", nm);
      end else begin
        // The first access-phase cycle is spent in the completer's SETUP state,
        // then WAIT_CYCLES low ACCESS cycles follow.
        check({nm, "_wait_cycles"}, n_low, (t == 0) ? 32'd1 : 32'd3);
      end
    end
    @(posedge clk); #1;
    psel = 2'b00;
    pen  = 1'b0;
    if (aborted) repeat (4) @(posedge clk);
    #0;
  endtask

  // PSEL and PENABLE together while the completer is idle.
  task automatic violate(input int t, input logic do_clr);
    psel = (t == 0) ? 2'b01 : 2'b10;
    pen  = 1'b1;
    clr  = do_clr;
    @(posedge clk); #1;
    psel = 2'b00;
    pen  = 1'b0;
    clr  = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    psel   = 2'b00;
    pen    = 1'b0;
    pwrite = 1'b0;
    paddr  = '0;
    pwdata = '0;
    pstrb  = '0;
    clr    = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_pready", {30'b0, rdy1, rdy0}, 32'd0);
    check("rst_pslverr", {30'b0, err1, err0}, 32'd0);
    check("rst_proto_err", {30'b0, perr1, perr0}, 32'd0);
    check("rst_prdata_u2", rd1, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero wait states: write then back-to-back read.
    xfer(0, "t1_wr", 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 0);
    xfer(0, "t1_rd", 1'b0, 32'h08, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 0);

    // Two wait states: read of a reset word.
    xfer(1, "t2_rd", 1'b0, 32'h04, 32'h0, 4'h0, 32'h0, 1'b0, 0);

    // Byte strobes, including the all-zero no-op strobe.
    xfer(1, "t3_wr_full", 1'b1, 32'h0C, 32'h11223344, 4'hF, 32'h0, 1'b0, 0);
    xfer(1, "t3_wr_strb5", 1'b1, 32'h0C, 32'hAABBCCDD, 4'h5, 32'h0, 1'b0, 0);
    xfer(1, "t3_rd", 1'b0, 32'h0C, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 0);
    xfer(1, "t3_wr_strb0", 1'b1, 32'h0C, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, 0);
    xfer(1, "t3_rd_after_noop", 1'b0, 32'h0C, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 0);

    // Decode errors; 0x40 would alias word 0 if the range check were missing.
    xfer(1, "t4_wr_oob", 1'b1, 32'h40, 32'h5A5A5A5A, 4'hF, 32'h0, 1'b1, 0);
    xfer(1, "t4_rd_unaligned", 1'b0, 32'h02, 32'h0, 4'h0, 32'h0, 1'b1, 0);
    xfer(1, "t4_rd_word0", 1'b0, 32'h00, 32'h0, 4'h0, 32'h0, 1'b0, 0);
    xfer(1, "t4_wr_last", 1'b1, 32'h3C, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 0);
    xfer(1, "t4_rd_last", 1'b0, 32'h3C, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 0);

    // Protocol violations and the sticky flag.
    violate(1, 1'b0);
    check("t5_idle_violation_u2", {31'b0, perr1}, 32'd1);
    check("t5_idle_violation_u0_untouched", {31'b0, perr0}, 32'd0);
    xfer(1, "t5_abort", 1'b1, 32'h0C, 32'h55555555, 4'hF, 32'h0, 1'b0, 3);
    check("t5_abort_proto_err", {31'b0, perr1}, 32'd1);
    xfer(1, "t5_rd_after_abort", 1'b0, 32'h0C, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 0);
    violate(1, 1'b1);
    check("t5_set_wins_over_clr", {31'b0, perr1}, 32'd1);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("t5_clr", {31'b0, perr1}, 32'd0);

    // Asynchronous reset in the middle of a waited write.
    xfer(1, "t6_wr_pre", 1'b1, 32'h10, 32'h12345678, 4'hF, 32'h0, 1'b0, 0);
    xfer(1, "t6_rd_pre", 1'b0, 32'h10, 32'h0, 4'h0, 32'h12345678, 1'b0, 0);
    violate(1, 1'b0);
    check("t6_proto_err_before_reset", {31'b0, perr1}, 32'd1);
    psel   = 2'b10;
    pen    = 1'b0;
    pwrite = 1'b1;
    paddr  = 32'h10;
    pwdata = 32'hABCDEF01;
    pstrb  = 4'hF;
    @(posedge clk); #1;
    pen = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_pready", {31'b0, rdy1}, 32'd0);
    check("t6_async_pslverr", {31'b0, err1}, 32'd0);
    check("t6_async_prdata", rd1, 32'd0);
    check("t6_async_proto_err", {31'b0, perr1}, 32'd0);
    psel = 2'b00;
    pen  = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(1, "t6_rd_after_reset", 1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0, 0);
    xfer(0, "t6_rd_u0_after_reset", 1'b0, 32'h08, 32'h0, 4'h0, 32'h0, 1'b0, 0);

    repeat (2) @(posedge clk);
    check("queues_drained", q0.size() + q1.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
